// File: rtl/led_mode_controller.sv
// ---------------------------------------------------------------------------
// led_mode_controller
//
// Debounces two raw board switches into a 2-bit mode and drives one LED:
// off, slow blink (1 Hz), fast blink (4 Hz) or solid on. Every mode change
// restarts the blink timer so that a new blink pattern always begins with a
// full high half-period.
//
// Parameters
//   CLK_HZ          input clock frequency (multiple of 8, >= 8)
//   DEBOUNCE_CYCLES stable-cycle count required to accept a switch change (>= 1)
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_switch_1  raw asynchronous switch, mode bit 0
//   i_switch_2  raw asynchronous switch, mode bit 1
//   o_led       registered LED drive
//   o_tick      one-cycle pulse on every blink-timer toggle of o_led
//   o_mode      registered debounced mode {switch_2, switch_1}
// ---------------------------------------------------------------------------
module led_mode_controller #(
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_switch_1,
   input  logic       i_switch_2,
   output logic       o_led,
   output logic       o_tick,
   output logic [1:0] o_mode
);

   localparam int HALF_SLOW = CLK_HZ / 2;
   localparam int HALF_FAST = CLK_HZ / 8;
   localparam int BW        = $clog2(HALF_SLOW);
   localparam int DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [BW-1:0] SLOW_LAST = BW'(HALF_SLOW - 1);
   localparam logic [BW-1:0] FAST_LAST = BW'(HALF_FAST - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_FAST  = 2'b10;
   localparam logic [1:0] MODE_SOLID = 2'b11;

   typedef enum logic [1:0] {
      S_OFF      = 2'd0,
      S_SOLID    = 2'd1,
      S_BLINK_HI = 2'd2,
      S_BLINK_LO = 2'd3
   } state_t;

   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    sync3_q, sync3_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    mode_prev_q, mode_prev_d;
   state_t        state_q, state_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic [BW-1:0] half_last;
   logic          led_q, led_d;
   logic          tick_q, tick_d;

   // Synchronizer and debouncer: the switch pair is debounced as one vector
   // so a simultaneous change of both switches yields a single mode step.
   always_comb begin
      sync1_d  = {i_switch_2, i_switch_1};
      sync2_d  = sync1_q;
      sync3_d  = sync2_q;
      db_cnt_d = db_cnt_q;
      mode_d   = mode_q;
      if ((sync2_q != sync3_q) || (sync2_q == mode_q)) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         mode_d   = sync2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DW'(1);
      end
   end

   // Blink FSM: a mode change (seen one edge after o_mode moves) restarts the
   // timer and wins over a terminal count in the same cycle, without a tick.
   always_comb begin
      mode_prev_d = mode_q;
      state_d     = state_q;
      blink_cnt_d = blink_cnt_q;
      tick_d      = 1'b0;
      half_last   = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;
      if (mode_q != mode_prev_q) begin
         blink_cnt_d = '0;
         case (mode_q)
            MODE_OFF:   state_d = S_OFF;
            MODE_SOLID: state_d = S_SOLID;
            default:    state_d = S_BLINK_HI;
         endcase
      end else begin
         case (state_q)
            S_BLINK_HI, S_BLINK_LO: begin
               if (blink_cnt_q >= half_last) begin
                  state_d     = (state_q == S_BLINK_HI) ? S_BLINK_LO : S_BLINK_HI;
                  blink_cnt_d = '0;
                  tick_d      = 1'b1;
               end else begin
                  blink_cnt_d = blink_cnt_q + BW'(1);
               end
            end
            default: begin
               blink_cnt_d = '0;
            end
         endcase
      end
      led_d = (state_d == S_SOLID) || (state_d == S_BLINK_HI);
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q     <= 2'b00;
         sync2_q     <= 2'b00;
         sync3_q     <= 2'b00;
         db_cnt_q    <= '0;
         mode_q      <= 2'b00;
         mode_prev_q <= 2'b00;
         state_q     <= S_OFF;
         blink_cnt_q <= '0;
         led_q       <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sync3_q     <= sync3_d;
         db_cnt_q    <= db_cnt_d;
         mode_q      <= mode_d;
         mode_prev_q <= mode_prev_d;
         state_q     <= state_d;
         blink_cnt_q <= blink_cnt_d;
         led_q       <= led_d;
         tick_q      <= tick_d;
      end
   end

   assign o_led  = led_q;
   assign o_tick = tick_q;
   assign o_mode = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// ---------------------------------------------------------------------------
// tb_led_mode_controller
//
// Directed scenarios plus randomized switch activity. A behavioural model
// predicts o_mode from the stability of the synchronized switch history and
// derives o_led/o_tick from the time elapsed since the last blink restart.
// ---------------------------------------------------------------------------
module tb_led_mode_controller;

   localparam int CLK_HZ    = 16;
   localparam int DB        = 4;
   localparam int HALF_SLOW = CLK_HZ / 2;
   localparam int HALF_FAST = CLK_HZ / 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       sw1;
   logic       sw2;
   logic       o_led;
   logic       o_tick;
   logic [1:0] o_mode;

   int n_checks = 0;
   int n_pass   = 0;

   led_mode_controller #(
      .CLK_HZ         (CLK_HZ),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_switch_1(sw1),
      .i_switch_2(sw2),
      .o_led     (o_led),
      .o_tick    (o_tick),
      .o_mode    (o_mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic       m_valid = 1'b0;
   logic [1:0] m_s1, m_s2;
   logic [1:0] m_mode, m_prev;
   logic [1:0] m_disp;
   int         m_restart;
   int         edge_n = 0;
   logic [1:0] hist[$];
   logic       exp_led, exp_tick;

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_mode = 2'b00; m_prev = 2'b00;
            m_disp = 2'b00; m_restart = edge_n;
            hist.delete();
            m_valid = 1'b1;
         end else if (m_valid) begin
            logic [1:0] nm;
            logic       stable;
            int         el, half;
            hist.push_back(m_s2);
            if (hist.size() > DB + 1) void'(hist.pop_front());
            stable = (hist.size() == DB + 1);
            foreach (hist[i]) if (hist[i] != m_s2) stable = 1'b0;
            nm = (stable && m_s2 != m_mode) ? m_s2 : m_mode;
            if (m_mode != m_prev) begin
               m_disp    = m_mode;
               m_restart = edge_n;
            end
            m_prev = m_mode;
            m_mode = nm;
            m_s2   = m_s1;
            m_s1   = {sw2, sw1};
            el   = edge_n - m_restart;
            half = (m_disp == 2'b10) ? HALF_FAST : HALF_SLOW;
         end
      end
   end

   // Expected LED/tick derived from elapsed time since the last restart.
   always_comb begin
      exp_led  = 1'b0;
      exp_tick = 1'b0;
      if (m_disp == 2'b11) begin
         exp_led = 1'b1;
      end else if (m_disp == 2'b01 || m_disp == 2'b10) begin
         int el, half;
         el       = edge_n - m_restart;
         half     = (m_disp == 2'b10) ? HALF_FAST : HALF_SLOW;
         exp_led  = ((el / half) % 2) == 0;
         exp_tick = (el > 0) && ((el % half) == 0);
      end else begin
         exp_led = 1'b0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) check("model", {28'd0, o_mode, o_led, o_tick}, {28'd0, m_mode, exp_led, exp_tick});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mode(input logic [1:0] want);
      int n = 0;
      while (o_mode != want && n < 200) begin step(); n++; end
      check("wait_mode", {30'd0, o_mode}, {30'd0, want});
   endtask

   // Wait for a toggle edge where the LED lands at the requested level.
   task automatic wait_toggle(input logic want_led);
      int n = 0;
      logic found = 1'b0;
      while (!found && n < 200) begin
         step(); n++;
         found = o_tick && (o_led == want_led);
      end
      check("wait_toggle", {31'd0, found}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
      step(); step();
      check("rst_led", {31'd0, o_led}, 32'd0);
      check("rst_tick", {31'd0, o_tick}, 32'd0);
      check("rst_mode", {30'd0, o_mode}, 32'd0);
      rst = 1'b0;
      repeat (50) step();
      check("idle_mode", {30'd0, o_mode}, 32'd0);
      check("idle_led", {31'd0, o_led}, 32'd0);

      // Switch 1 on: slow blink.
      sw1 = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         step();
         if (e == 6)  check("slow_mode_e6", {30'd0, o_mode}, 32'd0);
         if (e == 7)  check("slow_mode_e7", {30'd0, o_mode}, 32'd1);
         if (e == 7)  check("slow_led_e7", {31'd0, o_led}, 32'd0);
         if (e == 8)  check("slow_led_e8", {31'd0, o_led}, 32'd1);
         if (e == 8)  check("slow_tick_e8", {31'd0, o_tick}, 32'd0);
         if (e == 15) check("slow_led_e15", {31'd0, o_led}, 32'd1);
         if (e == 16) check("slow_led_e16", {31'd0, o_led}, 32'd0);
         if (e == 16) check("slow_tick_e16", {31'd0, o_tick}, 32'd1);
         if (e == 17) check("slow_tick_e17", {31'd0, o_tick}, 32'd0);
         if (e == 24) check("slow_led_e24", {31'd0, o_led}, 32'd1);
         if (e == 24) check("slow_tick_e24", {31'd0, o_tick}, 32'd1);
      end

      // SLOW -> FAST, restart lands 3 cycles into a high phase.
      wait_toggle(1'b0);
      step(); step(); step();
      sw1 = 1'b0; sw2 = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 7)  check("sf_mode_e7", {30'd0, o_mode}, 32'd2);
         if (e == 7)  check("sf_led_e7", {31'd0, o_led}, 32'd1);
         if (e == 8)  check("sf_led_e8", {31'd0, o_led}, 32'd1);
         if (e == 8)  check("sf_tick_e8", {31'd0, o_tick}, 32'd0);
         if (e == 9)  check("sf_led_e9", {31'd0, o_led}, 32'd1);
         if (e == 10) check("sf_led_e10", {31'd0, o_led}, 32'd0);
         if (e == 10) check("sf_tick_e10", {31'd0, o_tick}, 32'd1);
         if (e == 12) check("sf_led_e12", {31'd0, o_led}, 32'd1);
      end

      // Reset mid-high-phase with switches held at 01.
      sw1 = 1'b1; sw2 = 1'b0;
      wait_mode(2'b01);
      wait_toggle(1'b1);
      step(); step();
      rst = 1'b1;
      step();
      check("mrst_led", {31'd0, o_led}, 32'd0);
      check("mrst_mode", {30'd0, o_mode}, 32'd0);
      check("mrst_tick", {31'd0, o_tick}, 32'd0);
      rst = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         step();
         if (e == 6)  check("mrst_mode_e6", {30'd0, o_mode}, 32'd0);
         if (e == 7)  check("mrst_mode_e7", {30'd0, o_mode}, 32'd1);
         if (e == 8)  check("mrst_led_e8", {31'd0, o_led}, 32'd1);
         if (e == 16) check("mrst_tick_e16", {31'd0, o_tick}, 32'd1);
      end

      // Glitch rejection from mode 00.
      sw1 = 1'b0; sw2 = 1'b0;
      wait_mode(2'b00);
      repeat (4) step();
      sw2 = 1'b1;
      repeat (4) step();
      sw2 = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         step();
         check("glitch4_mode", {30'd0, o_mode}, 32'd0);
      end
      sw2 = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         step();
         if (e == 5)  sw2 = 1'b0;
         if (e == 6)  check("glitch5_mode_e6", {30'd0, o_mode}, 32'd0);
         if (e == 7)  check("glitch5_mode_e7", {30'd0, o_mode}, 32'd2);
         if (e == 11) check("glitch5_mode_e11", {30'd0, o_mode}, 32'd2);
         if (e == 12) check("glitch5_mode_e12", {30'd0, o_mode}, 32'd0);
      end

      // Both switches in the same cycle: 00 -> 11 directly.
      repeat (5) step();
      sw1 = 1'b1; sw2 = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         step();
         if (e == 6)  check("solid_mode_e6", {30'd0, o_mode}, 32'd0);
         if (e == 7)  check("solid_mode_e7", {30'd0, o_mode}, 32'd3);
         if (e == 8)  check("solid_led_e8", {31'd0, o_led}, 32'd1);
         if (e >= 8)  check("solid_tick", {31'd0, o_tick}, 32'd0);
         if (e == 30) check("solid_led_e30", {31'd0, o_led}, 32'd1);
      end

      // Randomized switch activity with occasional resets.
      for (int it = 0; it < 250; it++) begin
         int hold;
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) step();
            rst = 1'b0;
         end
         {sw2, sw1} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) hold = $urandom_range(8, 40);
         else hold = $urandom_range(1, 8);
         repeat (hold) step();
      end

      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/led_mode_controller.md
# led_mode_controller

Switch-driven LED mode controller. It debounces the two board switches into a 2-bit mode and owns the LED drive: off, slow blink (1 Hz), fast blink (4 Hz) or solid on. It replaces direct enable-to-LED wiring at the top level. It also sequences the blink enable counter, restarting it cleanly on every mode change.

## Interface
- `CLK_HZ`, default 50000000: input clock frequency. Must be a multiple of 8 and ≥ 8.
- `DEBOUNCE_CYCLES`, default 500000: stable-cycle count required to accept a switch change. Must be ≥ 1.
- `i_clk` input, 1 bit: single clock; all logic on the rising edge.
- `i_rst` input, 1 bit: reset, synchronous and active-high.
- `i_switch_1` input, 1 bit: raw asynchronous switch; mode bit 0.
- `i_switch_2` input, 1 bit: raw asynchronous switch; mode bit 1.
- `o_led` output, 1 bit: LED drive, registered.
- `o_tick` output, 1 bit: one-cycle pulse coincident with every blink-timer toggle of `o_led`.
- `o_mode` output, 2 bits: current debounced mode {switch_2, switch_1}, registered.

## Operation
- Derived constants:
  - `HALF_SLOW` = CLK_HZ/2
  - `HALF_FAST` = CLK_HZ/8
  - Blink counter width = clog2(HALF_SLOW).
- Synchronizer: the 2-bit switch vector passes through two flops, s1 then s2. A third flop, s3, holds the previous s2.
- Debouncer: treats the 2-bit vector as a unit, so intermediate modes never appear. At each edge:
  - if s2 != s3 or s2 == o_mode: clear cnt.
  - else if cnt == DEBOUNCE_CYCLES-1: set `o_mode` <= s2 and clear cnt.
  - else: increment cnt.
- Mode map:
  - 00 = OFF
  - 01 = SLOW
  - 10 = FAST
  - 11 = SOLID
- FSM states: S_OFF, S_SOLID, S_BLINK_HI, S_BLINK_LO.
- Mode-change detect: a register holds the previous `o_mode`. On the edge after `o_mode` changes, the FSM jumps to the entry state and clears the blink counter:
  - OFF → S_OFF
  - SOLID → S_SOLID
  - SLOW/FAST → S_BLINK_HI
- Blink states:
  - The counter increments each cycle.
  - When it reaches HALF-1 (HALF_SLOW or HALF_FAST per the current mode), the state toggles between HI and LO, the counter clears and `o_tick` pulses.
- Mode change has priority over a same-cycle terminal count. No `o_tick` is issued on a mode-change restart.
- `o_led` = 1 in S_SOLID and S_BLINK_HI; 0 otherwise.
- `o_tick` = 0 in S_OFF and S_SOLID.

## Timing
- Reset values (synchronous, takes effect at the first edge with `i_rst`=1):
  - `o_led`=0, `o_tick`=0, `o_mode`=00
  - s1/s2/s3 = 00, all counters 0, FSM in S_OFF
- Reset has priority over every other event.
- Reset mid-blink: outputs go to reset values at that edge. After release, held switches are re-debounced from scratch.
- Switch latency: an input change that is stable from before edge 1 updates `o_mode` at edge DEBOUNCE_CYCLES+3. `o_led` reflects the new mode at edge DEBOUNCE_CYCLES+4.
- Glitch rejection: the input must be stable for at least DEBOUNCE_CYCLES+1 consecutive cycles to be accepted. Any shorter pulse leaves `o_mode` unchanged.
- Any change of s2 during counting restarts the stability count.
- Steady blink: `o_led` is high for exactly HALF cycles and low for HALF cycles, starting high. `o_tick` pulses at each toggle edge, i.e. every HALF cycles.
- Mode change mid-phase (e.g. SLOW→FAST): the partially elapsed half-period is discarded. `o_led`=1 is held for a full new HALF starting at the restart edge.
- Simultaneous change of both switches: a single `o_mode` transition, with no intermediate value.
- Counter wrap: the blink counter never exceeds HALF_SLOW-1. The debounce counter never exceeds DEBOUNCE_CYCLES-1.

## Test plan
All scenarios use CLK_HZ=16 and DEBOUNCE_CYCLES=4, giving HALF_SLOW=8 and HALF_FAST=2.
- Reset, switches 00: assert `i_rst` for 2 cycles, run 50 cycles → `o_led`=0, `o_tick`=0, `o_mode`=00 throughout.
- Set `i_switch_1`=1 before edge 1:
  - `o_mode`=01 at edge 7.
  - `o_led`=1 from edge 8, toggles at edges 16, 24, 32, …
  - `o_tick` is high for exactly one cycle at each of those edges.
- Glitch rejection from mode 00:
  - a 4-cycle pulse on `i_switch_2` → `o_mode` stays 00.
  - a 5-cycle pulse → `o_mode`=10 at edge 7 after pulse start. After the pulse ends, `o_mode` returns to 00 another 7 edges later.
- SLOW→FAST mid-high-phase (3 cycles into the high phase):
  - `o_led` stays 1 until 2 cycles after the restart edge.
  - Then `o_led` alternates in 2-cycle halves.
  - No `o_tick` at the restart edge.
- Switches 00→11 in the same cycle:
  - `o_mode` goes directly 00→11 at edge 7.
  - `o_led`=1 from edge 8 and stays 1.
  - `o_tick` never asserts.
- Reset mid-blink with switches held at 01: reset for 1 cycle during a high phase → next edge `o_led`=0, `o_mode`=00. After release, `o_mode`=01 at edge 7 and blinking resumes high-first.
